// File: rtl/cnu_pkg.sv
// Shared definitions for the conditional negate unit: operand mode encodings.
package cnu_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ONES = 2'b01;
  localparam logic [MODE_W-1:0] MODE_NEG  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_ABS  = 2'b11;

endpackage

// File: rtl/cinv_bit.sv
// One C1 cell: conditional inverter, selects a or ~a by inv.
module cinv_bit (
  input  logic a,
  input  logic inv,
  output logic out
);

  assign out = inv ? ~a : a;

endmodule

// File: rtl/conditional_negate_unit.sv
// Registered W-bit pass / one's complement / negate / abs stage with valid/ready and overflow counter.
// Build option: define CNU_SAT_EN to saturate overflowed results to the largest positive value.
module conditional_negate_unit
  import cnu_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef CNU_SAT_EN
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
`endif

  logic         invert;
  logic         cin;
  logic         ovf_c;
  logic [W-1:0] inv_x;
  logic [W-1:0] carry;
  logic [W-1:0] sum;
  logic [W-1:0] result;
  logic         accept;

  // Mode decode: ABS only inverts negative operands; ONES inverts without the +1.
  always_comb begin
    invert = 1'b0;
    cin    = 1'b0;
    ovf_c  = 1'b0;
    unique case (in_mode)
      MODE_ONES: invert = 1'b1;
      MODE_NEG:  invert = 1'b1;
      MODE_ABS:  invert = in_data[W-1];
      default:   invert = 1'b0;
    endcase
    cin   = invert && (in_mode != MODE_ONES);
    ovf_c = ((in_mode == MODE_NEG) || (in_mode == MODE_ABS)) && (in_data == MIN_NEG);
  end

  assign carry[0] = cin;

  // Per-bit C1 cells followed by a ripple half-adder chain for the +1.
  for (genvar i = 0; i < W; i++) begin : g_bit
    cinv_bit u_cinv (
      .a   (in_data[i]),
      .inv (invert),
      .out (inv_x[i])
    );
    assign sum[i] = inv_x[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = inv_x[i] & carry[i];
    end
  end

`ifdef CNU_SAT_EN
  assign result = ovf_c ? MAX_POS : sum;
`else
  assign result = sum;
`endif

  // Single-entry output register: refill allowed in the same cycle it drains.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_ovf   <= ovf_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counts overflowed results as they are taken downstream; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conditional_negate_unit.sv
// Scoreboard bench for conditional_negate_unit (W=8, CNT_W=4); honours CNU_SAT_EN if defined.
module tb_conditional_negate_unit;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] ovf_count;

  exp_t q[$];
  int   exp_cnt;
  int   n_cmp;
  int   n_bad;

  conditional_negate_unit #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on signed integers, independent of the bit-level structure.
  function automatic exp_t model(input logic [W-1:0] x, input logic [1:0] m);
    exp_t e;
    int   sx;
    int   r;
    sx = int'($signed(x));
    case (m)
      2'b00:   r = sx;
      2'b01:   r = -sx - 1;
      2'b10:   r = -sx;
      default: r = (sx < 0) ? -sx : sx;
    endcase
    e.ovf  = (m[1] == 1'b1) && (sx == -128);
    e.data = r[W-1:0];
`ifdef CNU_SAT_EN
    if (e.ovf) e.data = 8'h7F;
`endif
    return e;
  endfunction

  // One clock of stimulus; outputs checked mid-cycle, counter checked after the edge.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [1:0] m, input logic ordy);
    logic acc;
    logic drn;
    @(negedge clk);
    rst = 1'b0;
    in_valid = v;
    in_data = x;
    in_mode = m;
    out_ready = ordy;
    #1;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'((q.size() == 0) || ordy));
    if (q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
    end
    acc = v && ((q.size() == 0) || ordy);
    drn = (q.size() != 0) && ordy;
    if (drn) begin
      if (q[0].ovf && exp_cnt < 15) exp_cnt++;
      void'(q.pop_front());
    end
    if (acc) q.push_back(model(x, m));
    @(posedge clk);
    #1;
    check("ovf_count", 32'(ovf_count), 32'(exp_cnt));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 2'b00;
    out_ready = 1'b1;

    do_reset(2);

    // Basic modes at full throughput
    step(1'b1, 8'h05, 2'b00, 1'b1);
    step(1'b1, 8'h05, 2'b01, 1'b1);
    step(1'b1, 8'h05, 2'b10, 1'b1);
    step(1'b1, 8'hFB, 2'b11, 1'b1);
    step(1'b1, 8'h05, 2'b11, 1'b1);
    step(1'b1, 8'h7F, 2'b10, 1'b1);
    step(1'b1, 8'h00, 2'b10, 1'b1);
    step(1'b1, 8'h80, 2'b01, 1'b1);
    step(1'b1, 8'h81, 2'b11, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b1);

    // Single overflow
    step(1'b1, 8'h80, 2'b10, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b1);
    check("ovf_count_one", 32'(ovf_count), 32'd1);

    // Backpressure on result 0xFB, then refill on the releasing edge
    step(1'b1, 8'h05, 2'b10, 1'b1);
    repeat (3) step(1'b1, 8'h33, 2'b00, 1'b0);
    step(1'b1, 8'h11, 2'b00, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b1);

    // Counter saturation, with non-counting PASS of 0x80 mixed in
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h80, (i % 2 == 0) ? 2'b10 : 2'b11, 1'b1);
      if (i % 5 == 0) step(1'b1, 8'h80, 2'b00, 1'b1);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1);
    check("ovf_count_sat", 32'(ovf_count), 32'd15);

    // Random traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end

    // Reset while a result is stalled
    step(1'b1, 8'h80, 2'b10, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b0);
    do_reset(1);
    step(1'b1, 8'h05, 2'b10, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
